// File: rtl/ac_controller_param.sv
// Air-conditioner controller: desired temperature set by edge-detected
// up/down buttons, simulated real temperature ramping toward it.
// Optional macro AC_DRIP_EN enables the drip-tray counter and pingando.
// Ports:
//   clk_2      in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   aumenta    in   raise-desired button (rising edge acts)
//   diminui    in   lower-desired button (rising edge acts)
//   desejo     out  desired temperature
//   real_temp  out  real temperature
//   state      out  00 ESTAVEL, 01 AUMENTANDO, 10 DIMINUINDO
//   pingando   out  drip indicator (0 when AC_DRIP_EN undefined)
module ac_controller_param #(
    parameter int TEMP_W      = 5,
    parameter int TEMP_MIN    = 20,
    parameter int TEMP_MAX    = 27,
    parameter int TEMP_RESET  = 20,
    parameter int STEP_CYCLES = 4,
    parameter int DRIP_STEPS  = 4
) (
    input  logic              clk_2,
    input  logic              reset,
    input  logic              aumenta,
    input  logic              diminui,
    output logic [TEMP_W-1:0] desejo,
    output logic [TEMP_W-1:0] real_temp,
    output logic [1:0]        state,
    output logic              pingando
);

    typedef enum logic [1:0] {
        ESTAVEL    = 2'b00,
        AUMENTANDO = 2'b01,
        DIMINUINDO = 2'b10
    } state_t;

    localparam int CNT_W =
        (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    localparam logic [TEMP_W-1:0] T_MIN = TEMP_W'(TEMP_MIN);
    localparam logic [TEMP_W-1:0] T_MAX = TEMP_W'(TEMP_MAX);
    localparam logic [TEMP_W-1:0] T_RST = TEMP_W'(TEMP_RESET);
    localparam logic [CNT_W-1:0]  STEP_LAST =
        CNT_W'(STEP_CYCLES - 1);

    logic              aumenta_q, aumenta_d;
    logic              diminui_q, diminui_d;
    logic [TEMP_W-1:0] desejo_q, desejo_d;
    logic [TEMP_W-1:0] real_q, real_d;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  step_cnt_q, step_cnt_d;
    logic              up_rise, dn_rise;
    logic              real_inc, real_dec;

    always_comb begin
        aumenta_d  = aumenta;
        diminui_d  = diminui;
        up_rise    = aumenta & ~aumenta_q;
        dn_rise    = diminui & ~diminui_q;
        desejo_d   = desejo_q;
        real_d     = real_q;
        state_d    = ESTAVEL;
        step_cnt_d = step_cnt_q;
        real_inc   = 1'b0;
        real_dec   = 1'b0;

        // Simultaneous rises cancel; limits saturate.
        if (up_rise && !dn_rise && desejo_q < T_MAX) begin
            desejo_d = desejo_q + 1'b1;
        end else if (dn_rise && !up_rise && desejo_q > T_MIN) begin
            desejo_d = desejo_q - 1'b1;
        end

        if (real_q < desejo_q) begin
            state_d = AUMENTANDO;
        end else if (real_q > desejo_q) begin
            state_d = DIMINUINDO;
        end

        // A direct AUMENTANDO<->DIMINUINDO swap restarts the step timer
        // just as passing through ESTAVEL would.
        if (state_q == ESTAVEL ||
            (state_d != ESTAVEL && state_d != state_q)) begin
            step_cnt_d = '0;
        end else if (step_cnt_q == STEP_LAST) begin
            step_cnt_d = '0;
            if (state_q == AUMENTANDO && real_q < desejo_q) begin
                real_inc = 1'b1;
            end else if (state_q == DIMINUINDO && real_q > desejo_q) begin
                real_dec = 1'b1;
            end
        end else begin
            step_cnt_d = step_cnt_q + 1'b1;
        end

        if (real_inc) begin
            real_d = real_q + 1'b1;
        end else if (real_dec) begin
            real_d = real_q - 1'b1;
        end
    end

    always_ff @(posedge clk_2) begin
        if (reset) begin
            aumenta_q  <= 1'b0;
            diminui_q  <= 1'b0;
            desejo_q   <= T_RST;
            real_q     <= T_RST;
            state_q    <= ESTAVEL;
            step_cnt_q <= '0;
        end else begin
            aumenta_q  <= aumenta_d;
            diminui_q  <= diminui_d;
            desejo_q   <= desejo_d;
            real_q     <= real_d;
            state_q    <= state_d;
            step_cnt_q <= step_cnt_d;
        end
    end

`ifdef AC_DRIP_EN
    localparam int DRIP_W = $clog2(DRIP_STEPS + 1);
    localparam logic [DRIP_W-1:0] DRIP_MAX = DRIP_W'(DRIP_STEPS);

    logic [DRIP_W-1:0] drip_cnt_q, drip_cnt_d;
    logic              pingando_q, pingando_d;

    always_comb begin
        drip_cnt_d = drip_cnt_q;
        pingando_d = (drip_cnt_q == DRIP_MAX);
        if (real_inc) begin
            drip_cnt_d = '0;
        end else if (real_dec && drip_cnt_q != DRIP_MAX) begin
            drip_cnt_d = drip_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_2) begin
        if (reset) begin
            drip_cnt_q <= '0;
            pingando_q <= 1'b0;
        end else begin
            drip_cnt_q <= drip_cnt_d;
            pingando_q <= pingando_d;
        end
    end

    assign pingando = pingando_q;
`else
    assign pingando = 1'b0;
`endif

    assign desejo    = desejo_q;
    assign real_temp = real_q;
    assign state     = state_q;

endmodule

// File: doc/ac_controller_param.md
Name: ac_controller_param

Overview:
- Parametrised air-conditioner temperature controller; next generation of the board-level AC state machine.
- Holds a desired temperature, set by edge-detected up/down buttons, and a simulated real temperature.
- Real temperature steps toward desired at a programmable rate; a drip-tray indicator tracks sustained cooling.
- Instantiated from the board top: SWI bits drive the buttons and reset; outputs go to LED/LCD debug.

Parameters:
- TEMP_W, 5, width of temperature registers (unsigned).
- TEMP_MIN, 20, lowest settable desired temperature.
- TEMP_MAX, 27, highest settable desired temperature.
- TEMP_RESET, 20, reset value of desired and real; must satisfy TEMP_MIN <= TEMP_RESET <= TEMP_MAX.
- STEP_CYCLES, 4, clock cycles per one-degree real-temperature step (>= 1).
- DRIP_STEPS, 4, consecutive cooling steps before pingando asserts (>= 1).

Ports:
- clk_2  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- aumenta  input  1  raise-desired button (level; rising edge acts).
- diminui  input  1  lower-desired button (level; rising edge acts).
- desejo  output  TEMP_W  desired temperature register.
- real_temp  output  TEMP_W  current real temperature register.
- state  output  2  00 ESTAVEL, 01 AUMENTANDO, 10 DIMINUINDO (11 never driven).
- pingando  output  1  drip indicator.

Behaviour:
- Reset is sampled at the clk_2 edge and overrides everything else. After reset: desejo=real_temp=TEMP_RESET, state=ESTAVEL, pingando=0. Step counter, drip counter and button history registers are all 0.
- Button edge detection: aumenta_q/diminui_q are registered copies of the inputs. up_rise = aumenta & ~aumenta_q; dn_rise = diminui & ~diminui_q.
- Desired update at the same edge that samples the rise:
  - up_rise & ~dn_rise & desejo<TEMP_MAX -> desejo+1.
  - dn_rise & ~up_rise & desejo>TEMP_MIN -> desejo-1.
  - Both rises together, or request at the limit -> no change (saturate, never wrap).
  - A held button gives exactly one change.
- State register is updated every cycle from the current registers: real<desejo -> AUMENTANDO; real>desejo -> DIMINUINDO; equal -> ESTAVEL. State therefore lags register changes by one cycle.
- Step counter:
  - Cleared and held at 0 in ESTAVEL.
  - Otherwise increments each cycle. At value STEP_CYCLES-1 it clears and real_temp moves one degree: AUMENTANDO & real<desejo -> +1; DIMINUINDO & real>desejo -> -1.
  - If the guard fails (desejo changed meanwhile), real holds; never overshoot.
- Latency: a single up press at edge e0 with real==desejo gives desejo at e0, state AUMENTANDO at e1, real+1 at e1+STEP_CYCLES, and ESTAVEL one edge later.
- Desired change mid-ramp: the counter is not reset while the state is non-ESTAVEL. A direction reversal does clear it, because the state passes through or changes direction.
- Drip counter: +1 on each real decrement, saturating at DRIP_STEPS. Cleared on any real increment; held in ESTAVEL. pingando is registered: 1 when the counter equals DRIP_STEPS, else 0.
- Reset mid-ramp returns all state to reset values at that edge; the ramp does not resume.

Optional Feature:
- AC_DRIP_EN: when defined, drip counter and pingando logic are as above.
- Undefined: no drip counter is synthesised; pingando is constant 0; all other behaviour is unchanged.

Test Plan:
- Reset with defaults -> desejo=20, real_temp=20, state=00, pingando=0.
- Pulse aumenta one cycle at e0 -> desejo=21 at e0, state=01 at e1, real_temp=21 at e5, state=00 at e6.
- Hold aumenta 10 cycles, then release/press 7 more times -> desejo increments once per press, saturates at 27; real ramps to 27 at 4 cycles/step.
- From real=desejo=27 press diminui 5 times -> real reaches 22. With AC_DRIP_EN, pingando=1 one cycle after the 4th decrement, stays 1 in ESTAVEL; one aumenta press then clears it after the next increment.
- aumenta and diminui rise same cycle -> desejo unchanged; desejo=20 plus diminui press -> stays 20.
- Reset asserted mid-ramp (real=23, desejo=26) -> next edge all outputs back to reset values; no further real steps.
